// File: rtl/stump_seq_shifter.sv
// rtl/stump_seq_shifter.sv - multi-cycle one-bit-per-clock shifter with start/busy/done handshake (optional abort port: STUMP_SHIFT_ABORT_EN)

module stump_seq_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_A,
  input  logic [AMT_W-1:0] amount,
  input  logic [2:0]       shift_op,
  input  logic             c_in,
`ifdef STUMP_SHIFT_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shift_out,
  output logic             c_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ASR  = 3'b001;
  localparam logic [2:0] OP_ROR  = 3'b010;
  localparam logic [2:0] OP_RRC  = 3'b011;
  localparam logic [2:0] OP_LSL  = 3'b100;
  localparam logic [2:0] OP_LSR  = 3'b101;

  logic [1:0]       state;
  logic [AMT_W-1:0] cnt;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] step_a;
  logic             step_c;
  logic             reserved_op;

  // Reserved op codes behave as PASS with a zero step count.
  assign reserved_op = (shift_op[2:1] == 2'b11);

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

  // One single-bit step of the latched op applied to the working register and carry.
  always_comb begin
    step_a = shift_out;
    step_c = c_out;
    case (op_r)
      OP_ASR: begin
        step_c = shift_out[0];
        step_a = {shift_out[WIDTH-1], shift_out[WIDTH-1:1]};
      end
      OP_ROR: begin
        step_c = shift_out[0];
        step_a = {shift_out[0], shift_out[WIDTH-1:1]};
      end
      OP_RRC: begin
        step_c = shift_out[0];
        step_a = {c_out, shift_out[WIDTH-1:1]};
      end
      OP_LSL: begin
        step_c = shift_out[WIDTH-1];
        step_a = {shift_out[WIDTH-2:0], 1'b0};
      end
      OP_LSR: begin
        step_c = shift_out[0];
        step_a = {1'b0, shift_out[WIDTH-1:1]};
      end
      default: begin
        step_a = shift_out;
        step_c = c_out;
      end
    endcase
  end

  // Control FSM plus working/result registers; start is accepted in IDLE or DONE only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op_r      <= OP_PASS;
      shift_out <= '0;
      c_out     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            shift_out <= operand_A;
            c_out     <= c_in;
            if (reserved_op) begin
              op_r  <= OP_PASS;
              cnt   <= '0;
              state <= ST_DONE;
            end else begin
              op_r  <= shift_op;
              cnt   <= amount;
              state <= (amount == '0) ? ST_DONE : ST_SHIFT;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          shift_out <= step_a;
          c_out     <= step_c;
          cnt       <= cnt - 1'b1;
`ifdef STUMP_SHIFT_ABORT_EN
          // An abort still commits this edge's step, leaving the partial result visible.
          if (abort) begin
            state <= ST_IDLE;
          end else if (cnt == AMT_W'(1)) begin
            state <= ST_DONE;
          end
`else
          if (cnt == AMT_W'(1)) begin
            state <= ST_DONE;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stump_seq_shifter.sv
// tb/tb_stump_seq_shifter.sv - directed self-checking bench for stump_seq_shifter

`timescale 1ns/1ps

module tb_stump_seq_shifter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] operand_A;
  logic [3:0]  amount;
  logic [2:0]  shift_op;
  logic        c_in;
  logic        busy;
  logic        done;
  logic [15:0] shift_out;
  logic        c_out;
`ifdef STUMP_SHIFT_ABORT_EN
  logic        abort;
`endif

  int tests;
  int fails;

  stump_seq_shifter #(.WIDTH(16), .AMT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .operand_A (operand_A),
    .amount    (amount),
    .shift_op  (shift_op),
    .c_in      (c_in),
`ifdef STUMP_SHIFT_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .shift_out (shift_out),
    .c_out     (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one start pulse from the current cycle, then count busy cycles until busy drops.
  task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [3:0] n,
                       input logic c, output int cyc);
    shift_op  = op;
    operand_A = a;
    amount    = n;
    c_in      = c;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if ({busy, done} !== 2'b00) begin
      fails++; $display("FAIL reset_flags busy/done=%b expected 00", {busy, done});
    end
    tests++;
    if (shift_out !== 16'h0000 || c_out !== 1'b0) begin
      fails++; $display("FAIL reset_regs shift_out=%h c_out=%b expected 0000/0", shift_out, c_out);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_asr();
    int cyc;
    do_op(3'b001, 16'h8018, 4'd4, 1'b0, cyc);
    tests++;
    if (cyc !== 4) begin fails++; $display("FAIL asr_busy_cycles got %0d expected 4", cyc); end
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL asr_done got %b expected 1", done); end
    tests++;
    if (shift_out !== 16'hF801 || c_out !== 1'b1) begin
      fails++; $display("FAIL asr_result got %h/%b expected F801/1", shift_out, c_out);
    end
    // No start in DONE: back to IDLE with result held.
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || shift_out !== 16'hF801 || c_out !== 1'b1) begin
      fails++; $display("FAIL asr_hold done=%b busy=%b out=%h c=%b expected 0/0/F801/1",
                        done, busy, shift_out, c_out);
    end
  endtask

  task automatic test_rotates();
    int cyc;
    do_op(3'b010, 16'h12AB, 4'd8, 1'b0, cyc);
    tests++;
    if (cyc !== 8 || done !== 1'b1 || shift_out !== 16'hAB12 || c_out !== 1'b1) begin
      fails++; $display("FAIL ror8 cyc=%0d done=%b out=%h c=%b expected 8/1/AB12/1",
                        cyc, done, shift_out, c_out);
    end
    @(posedge clk); #1;
    do_op(3'b011, 16'h0001, 4'd1, 1'b1, cyc);
    tests++;
    if (cyc !== 1 || done !== 1'b1 || shift_out !== 16'h8000 || c_out !== 1'b1) begin
      fails++; $display("FAIL rrc1 cyc=%0d done=%b out=%h c=%b expected 1/1/8000/1",
                        cyc, done, shift_out, c_out);
    end
    @(posedge clk); #1;
    do_op(3'b010, 16'h0001, 4'd15, 1'b1, cyc);
    tests++;
    if (cyc !== 15 || done !== 1'b1 || shift_out !== 16'h0002 || c_out !== 1'b0) begin
      fails++; $display("FAIL ror15 cyc=%0d done=%b out=%h c=%b expected 15/1/0002/0",
                        cyc, done, shift_out, c_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int cyc;
    do_op(3'b100, 16'hE001, 4'd3, 1'b0, cyc);
    tests++;
    if (cyc !== 3 || done !== 1'b1 || shift_out !== 16'h0008 || c_out !== 1'b1) begin
      fails++; $display("FAIL lsl3 cyc=%0d done=%b out=%h c=%b expected 3/1/0008/1",
                        cyc, done, shift_out, c_out);
    end
    // Start issued in the DONE cycle.
    do_op(3'b101, 16'h1234, 4'd0, 1'b1, cyc);
    tests++;
    if (cyc !== 0 || done !== 1'b1 || shift_out !== 16'h1234 || c_out !== 1'b1) begin
      fails++; $display("FAIL lsr0_b2b cyc=%0d done=%b out=%h c=%b expected 0/1/1234/1",
                        cyc, done, shift_out, c_out);
    end
    @(posedge clk); #1;
    do_op(3'b101, 16'hFFFF, 4'd15, 1'b0, cyc);
    tests++;
    if (cyc !== 15 || shift_out !== 16'h0001 || c_out !== 1'b1) begin
      fails++; $display("FAIL lsr15 cyc=%0d out=%h c=%b expected 15/0001/1", cyc, shift_out, c_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_pass_reserved();
    int cyc;
    do_op(3'b000, 16'h5A5A, 4'd3, 1'b1, cyc);
    tests++;
    if (cyc !== 3 || done !== 1'b1 || shift_out !== 16'h5A5A || c_out !== 1'b1) begin
      fails++; $display("FAIL pass3 cyc=%0d done=%b out=%h c=%b expected 3/1/5A5A/1",
                        cyc, done, shift_out, c_out);
    end
    @(posedge clk); #1;
    do_op(3'b110, 16'hC3C3, 4'd5, 1'b0, cyc);
    tests++;
    if (cyc !== 0 || done !== 1'b1 || shift_out !== 16'hC3C3 || c_out !== 1'b0) begin
      fails++; $display("FAIL reserved cyc=%0d done=%b out=%h c=%b expected 0/1/C3C3/0",
                        cyc, done, shift_out, c_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    int cyc;
    shift_op = 3'b001; operand_A = 16'h8018; amount = 4'd4; c_in = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    // Second SHIFT cycle: a competing request that must be dropped.
    shift_op = 3'b100; operand_A = 16'hFFFF; amount = 4'd1; c_in = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 2;
    while (busy && cyc < 40) begin
      cyc++;
      @(posedge clk); #1;
    end
    tests++;
    if (cyc !== 4 || done !== 1'b1 || shift_out !== 16'hF801 || c_out !== 1'b1) begin
      fails++; $display("FAIL start_in_shift cyc=%0d done=%b out=%h c=%b expected 4/1/F801/1",
                        cyc, done, shift_out, c_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_shift();
    shift_op = 3'b100; operand_A = 16'h0001; amount = 4'd5; c_in = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || shift_out !== 16'h0000 || c_out !== 1'b0) begin
      fails++; $display("FAIL rst_mid_shift busy=%b done=%b out=%h c=%b expected 0/0/0000/0",
                        busy, done, shift_out, c_out);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL rst_no_done busy=%b done=%b expected 0/0", busy, done);
    end
  endtask

`ifdef STUMP_SHIFT_ABORT_EN
  task automatic test_abort();
    shift_op = 3'b001; operand_A = 16'h8000; amount = 4'd6; c_in = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || shift_out !== 16'hF000) begin
      fails++; $display("FAIL abort busy=%b done=%b out=%h expected 0/0/F000", busy, done, shift_out);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || shift_out !== 16'hF000) begin
      fails++; $display("FAIL abort_hold done=%b out=%h expected 0/F000", done, shift_out);
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    start = 1'b0;
    operand_A = '0;
    amount = '0;
    shift_op = '0;
    c_in = 1'b0;
`ifdef STUMP_SHIFT_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_asr();
    test_rotates();
    test_back_to_back();
    test_pass_reserved();
    test_start_ignored();
    test_reset_mid_shift();
`ifdef STUMP_SHIFT_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
